// File: rtl/rd_buf_pkg.sv
// Shared definitions for the read reorder buffer: fixed CCI widths, slot record and
// the {zeros, tag} mdata packing also used by the write-side tagging.
package rd_buf_pkg;

    localparam int unsigned ADDR_LMT        = 20;
    localparam int unsigned MDATA           = 14;
    localparam int unsigned CACHE_WIDTH_DEF = 512;
    localparam int unsigned TAG_W_DEF       = 5;

    typedef struct packed {
        logic [ADDR_LMT-1:0] addr;
        logic                alloc;
        logic                valid;
    } slot_t;

    function automatic int unsigned depth_of(input int unsigned tag_w);
        return 32'd1 << tag_w;
    endfunction

    // Keeps only the low tag_w bits; everything above is forced to zero.
    function automatic logic [MDATA-1:0] pack_mdata(input logic [MDATA-1:0] tag,
                                                    input int unsigned     tag_w);
        logic [MDATA-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MDATA; i++) begin
            if (i < tag_w) begin
                m[i] = tag[i];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rd_reorder_buf_if.sv
// User request/response and CCI read port bundle; slave is the buffer's view.
interface rd_reorder_buf_if
    import rd_buf_pkg::*;
#(
    parameter int unsigned CACHE_WIDTH = CACHE_WIDTH_DEF
);

    logic [ADDR_LMT-1:0]    usr_rd_addr;
    logic                   usr_rd_en;
    logic                   usr_rd_full;
    logic [ADDR_LMT-1:0]    rd_req_addr;
    logic [MDATA-1:0]       rd_req_mdata;
    logic                   rd_req_en;
    logic                   rd_req_almostfull;
    logic                   rd_rsp_valid;
    logic [MDATA-1:0]       rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0] rd_rsp_data;
    logic                   usr_rsp_valid;
    logic [CACHE_WIDTH-1:0] usr_rsp_data;
    logic [ADDR_LMT-1:0]    usr_rsp_addr;
    logic                   usr_rsp_ready;
    logic                   empty;
    logic                   tag_err;

    modport slave (
        input  usr_rd_addr, usr_rd_en, rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata,
               rd_rsp_data, usr_rsp_ready,
        output usr_rd_full, rd_req_addr, rd_req_mdata, rd_req_en, usr_rsp_valid,
               usr_rsp_data, usr_rsp_addr, empty, tag_err
    );

    modport master (
        output usr_rd_addr, usr_rd_en, rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata,
               rd_rsp_data, usr_rsp_ready,
        input  usr_rd_full, rd_req_addr, rd_req_mdata, rd_req_en, usr_rsp_valid,
               usr_rsp_data, usr_rsp_addr, empty, tag_err
    );

endinterface

// File: rtl/rd_slot_ram.sv
// Line storage for the reorder slots: one write port for responses, one registered read
// port whose output register doubles as the user response data register.
module rd_slot_ram #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [TAG_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [TAG_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = 32'd1 << TAG_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rd_reorder_buf.sv
// Tags in-order line reads with a slot index, gathers out-of-order responses in a slot
// RAM and hands lines back to the user strictly in request order.
module rd_reorder_buf
    import rd_buf_pkg::*;
#(
    parameter int unsigned TAG_W       = TAG_W_DEF,
    parameter int unsigned CACHE_WIDTH = CACHE_WIDTH_DEF
) (
    input logic             clk,
    input logic             rst,
    rd_reorder_buf_if.slave bus
);

    localparam int unsigned    DEPTH    = depth_of(TAG_W);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

    slot_t               r_slot [DEPTH];
    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;
    logic                r_req_en;
    logic [ADDR_LMT-1:0] r_req_addr;
    logic [MDATA-1:0]    r_req_mdata;
    logic                r_rsp_valid;
    logic [ADDR_LMT-1:0] r_rsp_addr;
    logic                r_tag_err;

    logic                w_full;
    logic                w_accept;
    logic [TAG_W-1:0]    w_rsp_tag;
    logic                w_upper_zero;
    logic                w_rsp_ok;
    logic                w_rsp_bad;
    logic                w_load;

    always_comb begin
        w_full       = (r_count == FULL_CNT) | bus.rd_req_almostfull;
        w_accept     = bus.usr_rd_en & ~w_full;
        w_rsp_tag    = bus.rd_rsp_mdata[TAG_W-1:0];
        w_upper_zero = (bus.rd_rsp_mdata[MDATA-1:TAG_W] == '0);
        // Duplicates and responses to free slots are both rejected here.
        w_rsp_ok     = bus.rd_rsp_valid & r_slot[w_rsp_tag].alloc & ~r_slot[w_rsp_tag].valid
                       & w_upper_zero;
        w_rsp_bad    = bus.rd_rsp_valid & ~w_rsp_ok;
        w_load       = r_slot[r_head].valid & (~r_rsp_valid | bus.usr_rsp_ready);
    end

    // A loading head slot is always already valid, so it never collides with a response
    // write or an allocation in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_slot[r_head].alloc <= 1'b0;
                r_slot[r_head].valid <= 1'b0;
            end
            if (w_rsp_ok) begin
                r_slot[w_rsp_tag].valid <= 1'b1;
            end
            if (w_accept) begin
                r_slot[r_tail].addr  <= bus.usr_rd_addr;
                r_slot[r_tail].alloc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + TAG_W'(1);
            end
            if (w_load) begin
                r_head <= r_head + TAG_W'(1);
            end
            unique case ({w_accept, w_load})
                2'b10:   r_count <= r_count + (TAG_W + 1)'(1);
                2'b01:   r_count <= r_count - (TAG_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_en    <= 1'b0;
            r_req_addr  <= '0;
            r_req_mdata <= '0;
        end else begin
            r_req_en <= w_accept;
            if (w_accept) begin
                r_req_addr  <= bus.usr_rd_addr;
                r_req_mdata <= pack_mdata({{(MDATA - TAG_W){1'b0}}, r_tail}, TAG_W);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_tag_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_addr  <= r_slot[r_head].addr;
            end else if (bus.usr_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_rsp_bad) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    rd_slot_ram #(
        .TAG_W (TAG_W),
        .WIDTH (CACHE_WIDTH)
    ) u_slot_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_rsp_ok),
        .i_waddr (w_rsp_tag),
        .i_wdata (bus.rd_rsp_data),
        .i_re    (w_load),
        .i_raddr (r_head),
        .o_rdata (bus.usr_rsp_data)
    );

    assign bus.usr_rd_full   = w_full;
    assign bus.rd_req_en     = r_req_en;
    assign bus.rd_req_addr   = r_req_addr;
    assign bus.rd_req_mdata  = r_req_mdata;
    assign bus.usr_rsp_valid = r_rsp_valid;
    assign bus.usr_rsp_addr  = r_rsp_addr;
    assign bus.tag_err       = r_tag_err;
    assign bus.empty         = (r_count == '0) & ~r_rsp_valid;

endmodule

// File: tb/tb_rd_reorder_buf.sv
// Bench for rd_reorder_buf with a 4-slot buffer: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_rd_reorder_buf;
    import rd_buf_pkg::*;

    localparam int unsigned TW    = 2;
    localparam int          DEPTH = 4;
    localparam int unsigned CW    = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rd_reorder_buf_if #(.CACHE_WIDTH(CW)) bus ();

    rd_reorder_buf #(
        .TAG_W       (TW),
        .CACHE_WIDTH (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: requests in order, responses by tag, outputs from the head.
    int unsigned   cyc = 0;
    bit            m_live = 1'b0;
    int            m_order[$];
    int            m_tail;
    bit            m_alloc[DEPTH];
    bit            m_have[DEPTH];
    logic [CW-1:0] m_data[DEPTH];
    logic [19:0]   m_addr[DEPTH];
    logic          e_req_en, e_rsp_valid, e_tag_err;
    logic [19:0]   e_req_addr, e_rsp_addr;
    logic [13:0]   e_req_mdata;
    logic [CW-1:0] e_rsp_data;

    function automatic logic exp_full();
        return (m_order.size() == DEPTH) || (bus.rd_req_almostfull == 1'b1);
    endfunction

    always @(posedge clk) begin : model
        bit acc, ok, ret;
        int t, h;
        cyc++;
        if (rst) begin
            m_live = 1'b1;
            m_order.delete();
            m_tail = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_alloc[i] = 0;
                m_have[i]  = 0;
            end
            e_req_en = 0; e_req_addr = 0; e_req_mdata = 0;
            e_rsp_valid = 0; e_rsp_data = 0; e_rsp_addr = 0; e_tag_err = 0;
        end else if (m_live) begin
            acc = bus.usr_rd_en && !exp_full();
            t   = int'(bus.rd_rsp_mdata) % DEPTH;
            ok  = bus.rd_rsp_valid && (int'(bus.rd_rsp_mdata) < DEPTH) && m_alloc[t] && !m_have[t];
            ret = (m_order.size() > 0) && m_have[m_order[0]] && (!e_rsp_valid || bus.usr_rsp_ready);
            if (ret) begin
                h = m_order.pop_front();
                e_rsp_valid = 1; e_rsp_data = m_data[h]; e_rsp_addr = m_addr[h];
                m_alloc[h] = 0; m_have[h] = 0;
            end else if (bus.usr_rsp_ready) begin
                e_rsp_valid = 0;
            end
            if (ok) begin
                m_have[t] = 1;
                m_data[t] = bus.rd_rsp_data;
            end else if (bus.rd_rsp_valid) begin
                e_tag_err = 1;
            end
            e_req_en = acc;
            if (acc) begin
                m_addr[m_tail] = bus.usr_rd_addr;
                m_alloc[m_tail] = 1;
                m_order.push_back(m_tail);
                e_req_addr = bus.usr_rd_addr;
                e_req_mdata = 14'(m_tail);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_full",      CW'(bus.usr_rd_full),   CW'(exp_full()));
            chk("m_req_en",    CW'(bus.rd_req_en),     CW'(e_req_en));
            chk("m_req_addr",  CW'(bus.rd_req_addr),   CW'(e_req_addr));
            chk("m_req_mdata", CW'(bus.rd_req_mdata),  CW'(e_req_mdata));
            chk("m_rsp_valid", CW'(bus.usr_rsp_valid), CW'(e_rsp_valid));
            chk("m_rsp_data",  bus.usr_rsp_data,       e_rsp_data);
            chk("m_rsp_addr",  CW'(bus.usr_rsp_addr),  CW'(e_rsp_addr));
            chk("m_tag_err",   CW'(bus.tag_err),       CW'(e_tag_err));
            chk("m_empty",     CW'(bus.empty),         CW'((m_order.size() == 0) && !e_rsp_valid));
        end
    end

    // Capture of consumed lines for the directed literal checks.
    logic [CW-1:0] got_data[$];
    logic [19:0]   got_addr[$];
    int            got_cyc[$];
    bit            any_valid;
    int            first_valid_cyc;

    always @(negedge clk) begin
        if (m_live && !rst && bus.usr_rsp_valid === 1'b1) begin
            any_valid = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = int'(cyc);
            if (bus.usr_rsp_ready === 1'b1) begin
                got_data.push_back(bus.usr_rsp_data);
                got_addr.push_back(bus.usr_rsp_addr);
                got_cyc.push_back(int'(cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        got_data.delete(); got_addr.delete(); got_cyc.delete();
        any_valid = 1'b0;
        first_valid_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_cap();
    endtask

    task automatic req(input logic [19:0] addr);
        bus.usr_rd_en = 1'b1; bus.usr_rd_addr = addr;
        tick();
        bus.usr_rd_en = 1'b0;
    endtask

    task automatic rsp_raw(input logic [13:0] mdata, input logic [CW-1:0] data);
        bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = mdata; bus.rd_rsp_data = data;
        tick();
        bus.rd_rsp_valid = 1'b0;
    endtask

    task automatic chk_lines(input string name, input int n, input logic [CW-1:0] d0,
                             input logic [19:0] a0);
        chk({name, "_count"}, CW'(got_data.size()), CW'(n));
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            chk({name, "_data"}, got_data[i], d0 + CW'(i));
            chk({name, "_addr"}, CW'(got_addr[i]), CW'(a0 + 20'(i)));
            if (i > 0) chk({name, "_gap"}, CW'(got_cyc[i] - got_cyc[i-1]), CW'(1));
        end
    endtask

    initial begin
        int t0;
        bus.usr_rd_en = 0; bus.usr_rd_addr = 0; bus.rd_req_almostfull = 0;
        bus.rd_rsp_valid = 0; bus.rd_rsp_mdata = 0; bus.rd_rsp_data = 0;
        bus.usr_rsp_ready = 1;
        clear_cap();
        tick();
        do_reset();

        chk("rst_req_en",    CW'(bus.rd_req_en),     CW'(0));
        chk("rst_req_addr",  CW'(bus.rd_req_addr),   CW'(0));
        chk("rst_req_mdata", CW'(bus.rd_req_mdata),  CW'(0));
        chk("rst_rsp_valid", CW'(bus.usr_rsp_valid), CW'(0));
        chk("rst_rsp_data",  bus.usr_rsp_data,       CW'(0));
        chk("rst_rsp_addr",  CW'(bus.usr_rsp_addr),  CW'(0));
        chk("rst_tag_err",   CW'(bus.tag_err),       CW'(0));
        chk("rst_empty",     CW'(bus.empty),         CW'(1));

        // In-order responses
        for (int i = 0; i < 4; i++) req(20'h10 + 20'(i));
        chk("inord_mdata3", CW'(bus.rd_req_mdata), CW'(3));
        t0 = int'(cyc);
        for (int i = 0; i < 4; i++) rsp_raw(14'(i), CW'('hA0 + i));
        repeat (6) tick();
        chk("inord_latency", CW'(first_valid_cyc - t0), CW'(2));
        chk_lines("inord", 4, CW'('hA0), 20'h10);
        chk("inord_empty", CW'(bus.empty), CW'(1));

        // Reverse-order responses
        do_reset();
        for (int i = 0; i < 4; i++) req(20'h10 + 20'(i));
        for (int i = 3; i > 0; i--) rsp_raw(14'(i), CW'('hA0 + i));
        repeat (3) tick();
        chk("rev_hold", CW'(any_valid), CW'(0));
        t0 = int'(cyc);
        rsp_raw(14'(0), CW'('hA0));
        repeat (8) tick();
        chk("rev_latency", CW'(first_valid_cyc - t0), CW'(2));
        chk_lines("rev", 4, CW'('hA0), 20'h10);

        // Full and backpressure
        do_reset();
        for (int i = 0; i < 4; i++) req(20'h10 + 20'(i));
        chk("full_at4", CW'(bus.usr_rd_full), CW'(1));
        req(20'h99);
        chk("full_noreq", CW'(bus.rd_req_en), CW'(0));
        rsp_raw(14'(0), CW'('hA0));
        repeat (4) tick();
        chk("full_after_retire", CW'(bus.usr_rd_full), CW'(0));
        req(20'h20);
        chk("wrap_req_en", CW'(bus.rd_req_en), CW'(1));
        chk("wrap_mdata",  CW'(bus.rd_req_mdata), CW'(0));
        chk("wrap_addr",   CW'(bus.rd_req_addr), CW'(20'h20));
        do_reset();
        bus.rd_req_almostfull = 1'b1;
        #1;
        chk("af_full", CW'(bus.usr_rd_full), CW'(1));
        req(20'h30);
        chk("af_noreq", CW'(bus.rd_req_en), CW'(0));
        bus.rd_req_almostfull = 1'b0;
        tick();

        // Consumer stall
        do_reset();
        bus.usr_rsp_ready = 1'b0;
        req(20'h10); req(20'h11);
        rsp_raw(14'(0), CW'('hA0)); rsp_raw(14'(1), CW'('hA1));
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", CW'(bus.usr_rsp_valid), CW'(1));
            chk("stall_data",  bus.usr_rsp_data, CW'('hA0));
            tick();
        end
        chk("stall_none", CW'(got_data.size()), CW'(0));
        bus.usr_rsp_ready = 1'b1;
        repeat (4) tick();
        chk_lines("stall", 2, CW'('hA0), 20'h10);

        // Bad tags
        do_reset();
        rsp_raw(14'(2), CW'('hBAD));
        chk("bad_unalloc_err", CW'(bus.tag_err), CW'(1));
        chk("bad_unalloc_val", CW'(bus.usr_rsp_valid), CW'(0));
        do_reset();
        chk("bad_rst_clear", CW'(bus.tag_err), CW'(0));
        req(20'h40); req(20'h41);
        rsp_raw(14'h1001, CW'('hBB));
        tick();
        chk("bad_upper_err", CW'(bus.tag_err), CW'(1));
        chk("bad_upper_val", CW'(any_valid), CW'(0));
        rsp_raw(14'(0), CW'('hC0)); rsp_raw(14'(1), CW'('hC1));
        repeat (5) tick();
        chk_lines("bad_after", 2, CW'('hC0), 20'h40);
        chk("bad_sticky", CW'(bus.tag_err), CW'(1));

        // Reset mid-flight
        do_reset();
        for (int i = 0; i < 3; i++) req(20'h60 + 20'(i));
        do_reset();
        chk("mid_rst_req_en", CW'(bus.rd_req_en), CW'(0));
        chk("mid_rst_empty",  CW'(bus.empty), CW'(1));
        for (int i = 0; i < 3; i++) rsp_raw(14'(i), CW'('hD0 + i));
        repeat (4) tick();
        chk("mid_tag_err",  CW'(bus.tag_err), CW'(1));
        chk("mid_no_valid", CW'(any_valid), CW'(0));
        chk("mid_empty",    CW'(bus.empty), CW'(1));
        req(20'h70);
        chk("mid_new_en",    CW'(bus.rd_req_en), CW'(1));
        chk("mid_new_mdata", CW'(bus.rd_req_mdata), CW'(0));
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
